bypass_source_pipe: RTL and testbench

//  Producer side of the operand-bypass interface. Tracks destination tags, write enables
//  and result data through the EX, MEM and WB stages. Drives Rd_EX/Rd_MEM/RegWrite_EX/

---
 rtl/bypass_source_pipe.sv | 157 +++++++++++++++
 tb/tb_bypass_source_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_source_pipe.sv
// Producer side of the operand-bypass path: carries destination tags, write
// enables and result data through EX, MEM and WB, exposes the EX/MEM bypass
// sources to the forwarding unit, and raises load-use and memory-wait stalls.
// A saturating wait counter drives a sticky memory-timeout flag.
module bypass_source_pipe #(
  parameter int DATA_W      = 64,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [4:0]        id_srca,
  input  logic [4:0]        id_srcb,
  input  logic              id_uses_a,
  input  logic              id_uses_b,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [4:0]        Rd_EX,
  output logic [4:0]        Rd_MEM,
  output logic              RegWrite_EX,
  output logic              RegWrite_MEM,
  output logic [DATA_W-1:0] fwd_data_ex,
  output logic [DATA_W-1:0] fwd_data_mem,
  output logic              stall_id,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_timeout
);

  // X31 is the zero register: never a hazard source, never written.
  localparam logic [4:0] XZR         = 5'd31;
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  // EX stage
  logic              ex_v;
  logic [4:0]        ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  // MEM stage
  logic              mem_v;
  logic [4:0]        mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  logic [DATA_W-1:0] mem_data;
  // WB stage (rd and data live directly in the wb_rd / wb_data outputs)
  logic              wb_v;
  logic              wb_regwrite;
  // Wait tracking
  logic [7:0]        wait_cnt;
  logic              pend_flush;

  logic              mem_wait;
  logic              load_use;
  logic              ex_bubble;
  logic [7:0]        wait_inc;

  // Hazard detection and bypass outputs
  always_comb begin
    mem_wait     = mem_v & mem_memread & ~mem_ready;
    load_use     = ex_v & ex_memread & ex_regwrite & (ex_rd != XZR) &
                   ((id_uses_a & (id_srca == ex_rd)) | (id_uses_b & (id_srcb == ex_rd)));
    stall_id     = id_valid & (mem_wait | load_use);
    ex_bubble    = load_use | ~id_valid | flush | pend_flush;
    wait_inc     = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    Rd_EX        = ex_rd;
    RegWrite_EX  = ex_v & ex_regwrite & ~ex_memread;
    fwd_data_ex  = ex_result;
    Rd_MEM       = mem_rd;
    RegWrite_MEM = mem_v & mem_regwrite;
    fwd_data_mem = mem_memread ? mem_rdata : mem_data;
    wb_en        = wb_v & wb_regwrite & (wb_rd != XZR);
  end

  // EX stage: hold during memory wait, otherwise take ID or a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v        <= 1'b0;
      ex_rd       <= XZR;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
    end else if (!mem_wait) begin
      if (ex_bubble) begin
        ex_v <= 1'b0;
      end else begin
        ex_v        <= 1'b1;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end
    end
  end

  // MEM stage: hold during memory wait, otherwise capture EX and its ALU result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_v        <= 1'b0;
      mem_rd       <= XZR;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_data     <= '0;
    end else if (!mem_wait) begin
      mem_v        <= ex_v;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      mem_data     <= ex_result;
    end
  end

  // WB stage: bubble while MEM waits, otherwise capture MEM (load data for loads)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_v        <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= XZR;
      wb_data     <= '0;
    end else if (mem_wait) begin
      wb_v <= 1'b0;
    end else begin
      wb_v        <= mem_v;
      wb_regwrite <= mem_regwrite;
      wb_rd       <= mem_rd;
      wb_data     <= mem_memread ? mem_rdata : mem_data;
    end
  end

  // Remember a flush that arrived while the pipe was frozen; drop it on the next advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_flush <= 1'b0;
    end else if (mem_wait) begin
      if (flush) pend_flush <= 1'b1;
    end else begin
      pend_flush <= 1'b0;
    end
  end

  // Count consecutive wait cycles and latch the timeout flag once the limit is hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else if (mem_wait) begin
      wait_cnt <= wait_inc;
      if (wait_inc >= TIMEOUT_CNT) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_bypass_source_pipe.sv
// Directed bench for bypass_source_pipe: forwarding tags, load-use stall,
// memory wait, X31 handling, flush during wait, timeout and mid-stall reset.
module tb_bypass_source_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rd = 5'd0;
  logic        id_regwrite = 1'b0;
  logic        id_memread = 1'b0;
  logic [4:0]  id_srca = 5'd0;
  logic [4:0]  id_srcb = 5'd0;
  logic        id_uses_a = 1'b0;
  logic        id_uses_b = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] ex_result = 64'd0;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_ready = 1'b1;
  logic [4:0]  Rd_EX, Rd_MEM, wb_rd;
  logic        RegWrite_EX, RegWrite_MEM, stall_id, wb_en, mem_timeout;
  logic [63:0] fwd_data_ex, fwd_data_mem, wb_data;

  int vectors = 0;
  int miscompares = 0;

  bypass_source_pipe #(.DATA_W(64), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_srca(id_srca),
    .id_srcb(id_srcb), .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .flush(flush), .ex_result(ex_result), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM),
    .fwd_data_ex(fwd_data_ex), .fwd_data_mem(fwd_data_mem),
    .stall_id(stall_id), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Load the ID-stage inputs
  task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] sa, input logic [4:0] sb, input logic ua, input logic ub);
    id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr;
    id_srca = sa; id_srcb = sb; id_uses_a = ua; id_uses_b = ub;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 0; mem_ready = 1; ex_result = 0; mem_rdata = 0;
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++; if (Rd_EX !== 5'd31) begin miscompares++; $display("FAIL reset_rd_ex got %0d want 31", Rd_EX); end
    vectors++; if (Rd_MEM !== 5'd31) begin miscompares++; $display("FAIL reset_rd_mem got %0d want 31", Rd_MEM); end
    vectors++; if (wb_rd !== 5'd31) begin miscompares++; $display("FAIL reset_wb_rd got %0d want 31", wb_rd); end
    vectors++; if ({RegWrite_EX, RegWrite_MEM, wb_en, stall_id, mem_timeout} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags got %b want 00000", {RegWrite_EX, RegWrite_MEM, wb_en, stall_id, mem_timeout}); end
    vectors++; if (wb_data !== 64'd0 || fwd_data_mem !== 64'd0) begin
      miscompares++; $display("FAIL reset_data got wb=%h mem=%h want 0", wb_data, fwd_data_mem); end
    step();
  endtask

  task automatic test_ex_forward();
    do_reset();
    set_id(1, 1, 1, 0, 2, 3, 1, 1);          // ADD X1
    step();
    set_id(1, 4, 1, 0, 1, 5, 1, 1);          // SUB X4, X1, X5
    ex_result = 64'h1234;
    @(negedge clk);
    vectors++; if (Rd_EX !== 5'd1) begin miscompares++; $display("FAIL ex_fwd_rd got %0d want 1", Rd_EX); end
    vectors++; if (RegWrite_EX !== 1'b1) begin miscompares++; $display("FAIL ex_fwd_regwrite got %b want 1", RegWrite_EX); end
    vectors++; if (fwd_data_ex !== 64'h1234) begin miscompares++; $display("FAIL ex_fwd_data got %h want 1234", fwd_data_ex); end
    vectors++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL ex_fwd_stall got %b want 0", stall_id); end
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_result = 64'h5555;
    @(negedge clk);
    vectors++; if (Rd_MEM !== 5'd1 || RegWrite_MEM !== 1'b1) begin
      miscompares++; $display("FAIL mem_fwd_tag got rd=%0d rw=%b want rd=1 rw=1", Rd_MEM, RegWrite_MEM); end
    vectors++; if (fwd_data_mem !== 64'h1234) begin miscompares++; $display("FAIL mem_fwd_data got %h want 1234", fwd_data_mem); end
    vectors++; if (Rd_EX !== 5'd4) begin miscompares++; $display("FAIL ex_next_rd got %0d want 4", Rd_EX); end
    step();
    @(negedge clk);
    vectors++; if (wb_en !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 64'h1234) begin
      miscompares++; $display("FAIL wb_add got en=%b rd=%0d data=%h want en=1 rd=1 data=1234", wb_en, wb_rd, wb_data); end
    step();
    @(negedge clk);
    vectors++; if (wb_en !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 64'h5555) begin
      miscompares++; $display("FAIL wb_sub got en=%b rd=%0d data=%h want en=1 rd=4 data=5555", wb_en, wb_rd, wb_data); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 2, 1, 1, 0, 0, 0, 0);          // LDR X2
    step();
    set_id(1, 3, 1, 0, 7, 2, 0, 1);          // ADD X3, X7, X2 (X2 via srcb)
    mem_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    vectors++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", stall_id); end
    step();
    @(negedge clk);
    vectors++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL lu_stall_release got %b want 0", stall_id); end
    vectors++; if (RegWrite_EX !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got %b want 0", RegWrite_EX); end
    vectors++; if (Rd_MEM !== 5'd2 || RegWrite_MEM !== 1'b1) begin
      miscompares++; $display("FAIL lu_mem_tag got rd=%0d rw=%b want rd=2 rw=1", Rd_MEM, RegWrite_MEM); end
    vectors++; if (fwd_data_mem !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL lu_mem_data got %h want deadbeef", fwd_data_mem); end
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++; if (Rd_EX !== 5'd3 || RegWrite_EX !== 1'b1) begin
      miscompares++; $display("FAIL lu_add_ex got rd=%0d rw=%b want rd=3 rw=1", Rd_EX, RegWrite_EX); end
    vectors++; if (wb_en !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 64'hDEAD_BEEF) begin
      miscompares++; $display("FAIL lu_wb got en=%b rd=%0d data=%h want en=1 rd=2 data=deadbeef", wb_en, wb_rd, wb_data); end
    step();
  endtask

  task automatic test_mem_wait();
    int writes = 0;
    do_reset();
    set_id(1, 5, 1, 1, 0, 0, 0, 0);          // LDR X5
    step();
    set_id(1, 6, 1, 0, 7, 8, 1, 1);          // ADD X6, independent
    mem_ready = 0;
    @(negedge clk);
    vectors++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL mw_pre_stall got %b want 0", stall_id); end
    step();
    set_id(1, 8, 1, 0, 9, 9, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_en && wb_rd == 5'd5) writes++;
      vectors++; if (stall_id !== 1'b1 || Rd_MEM !== 5'd5 || Rd_EX !== 5'd6 || wb_en !== 1'b0) begin
        miscompares++; $display("FAIL mw_hold[%0d] got stall=%b rd_mem=%0d rd_ex=%0d wb_en=%b want 1/5/6/0", i, stall_id, Rd_MEM, Rd_EX, wb_en); end
      step();
    end
    mem_ready = 1; mem_rdata = 64'hCAFE; ex_result = 64'h66;
    @(negedge clk);
    vectors++; if (stall_id !== 1'b0 || fwd_data_mem !== 64'hCAFE) begin
      miscompares++; $display("FAIL mw_release got stall=%b data=%h want 0/cafe", stall_id, fwd_data_mem); end
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (wb_en && wb_rd == 5'd5) writes++;
    vectors++; if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'hCAFE) begin
      miscompares++; $display("FAIL mw_wb_load got en=%b rd=%0d data=%h want en=1 rd=5 data=cafe", wb_en, wb_rd, wb_data); end
    step();
    @(negedge clk);
    if (wb_en && wb_rd == 5'd5) writes++;
    vectors++; if (wb_en !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 64'h66) begin
      miscompares++; $display("FAIL mw_wb_add got en=%b rd=%0d data=%h want en=1 rd=6 data=66", wb_en, wb_rd, wb_data); end
    step();
    @(negedge clk);
    if (wb_en && wb_rd == 5'd5) writes++;
    vectors++; if (writes !== 1) begin miscompares++; $display("FAIL mw_single_write got %0d want 1", writes); end
    vectors++; if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL mw_no_timeout got %b want 0", mem_timeout); end
    step();
  endtask

  task automatic test_x31();
    do_reset();
    set_id(1, 31, 1, 1, 0, 0, 0, 0);         // LDR X31
    step();
    set_id(1, 31, 1, 0, 31, 31, 1, 1);       // ADD X31 reading X31
    @(negedge clk);
    vectors++; if (stall_id !== 1'b0) begin miscompares++; $display("FAIL x31_no_stall got %b want 0", stall_id); end
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++; if (Rd_EX !== 5'd31 || RegWrite_EX !== 1'b1 || RegWrite_MEM !== 1'b1) begin
      miscompares++; $display("FAIL x31_regwrite got rd=%0d rw_ex=%b rw_mem=%b want 31/1/1", Rd_EX, RegWrite_EX, RegWrite_MEM); end
    step();
    @(negedge clk);
    vectors++; if (wb_en !== 1'b0 || wb_rd !== 5'd31) begin
      miscompares++; $display("FAIL x31_wb_load got en=%b rd=%0d want en=0 rd=31", wb_en, wb_rd); end
    step();
    @(negedge clk);
    vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("FAIL x31_wb_add got %b want 0", wb_en); end
    step();
  endtask

  task automatic test_flush_in_wait();
    do_reset();
    set_id(1, 10, 1, 1, 0, 0, 0, 0);         // LDR X10
    step();
    set_id(1, 11, 1, 0, 1, 1, 1, 1);         // ADD X11
    mem_ready = 0;
    step();
    set_id(1, 12, 1, 0, 1, 1, 1, 1);         // ADD X12, killed by flush
    flush = 1;
    @(negedge clk);
    vectors++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL fl_stall got %b want 1", stall_id); end
    step();
    flush = 0; mem_ready = 1; mem_rdata = 64'hAA; ex_result = 64'hBB;
    @(negedge clk);
    vectors++; if (dut.pend_flush !== 1'b1) begin miscompares++; $display("FAIL fl_pending got %b want 1", dut.pend_flush); end
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++; if (RegWrite_EX !== 1'b0 || dut.pend_flush !== 1'b0) begin
      miscompares++; $display("FAIL fl_bubble got rw_ex=%b pend=%b want 0/0", RegWrite_EX, dut.pend_flush); end
    vectors++; if (wb_en !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 64'hAA) begin
      miscompares++; $display("FAIL fl_wb_load got en=%b rd=%0d data=%h want en=1 rd=10 data=aa", wb_en, wb_rd, wb_data); end
    step();
    @(negedge clk);
    vectors++; if (wb_en !== 1'b1 || wb_rd !== 5'd11 || wb_data !== 64'hBB) begin
      miscompares++; $display("FAIL fl_wb_add got en=%b rd=%0d data=%h want en=1 rd=11 data=bb", wb_en, wb_rd, wb_data); end
    step();
    @(negedge clk);
    vectors++; if (wb_en !== 1'b0) begin miscompares++; $display("FAIL fl_no_wb got en=%b rd=%0d want en=0", wb_en, wb_rd); end
    step();
  endtask

  task automatic test_timeout_and_reset();
    do_reset();
    set_id(1, 4, 1, 1, 0, 0, 0, 0);          // LDR X4
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    mem_ready = 0;
    step();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vectors++; if (mem_timeout !== (i >= 4)) begin
        miscompares++; $display("FAIL timeout[%0d] got %b want %b", i, mem_timeout, (i >= 4)); end
      step();
    end
    set_id(1, 7, 1, 0, 1, 2, 1, 1);
    @(negedge clk);
    vectors++; if (stall_id !== 1'b1) begin miscompares++; $display("FAIL to_stall got %b want 1", stall_id); end
    #1 reset = 1;
    #1;
    vectors++; if (Rd_EX !== 5'd31 || Rd_MEM !== 5'd31 || wb_rd !== 5'd31) begin
      miscompares++; $display("FAIL mid_reset_tags got %0d/%0d/%0d want 31/31/31", Rd_EX, Rd_MEM, wb_rd); end
    vectors++; if ({RegWrite_EX, RegWrite_MEM, wb_en, stall_id, mem_timeout} !== 5'b0) begin
      miscompares++; $display("FAIL mid_reset_flags got %b want 00000", {RegWrite_EX, RegWrite_MEM, wb_en, stall_id, mem_timeout}); end
    step();
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use();
    test_mem_wait();
    test_x31();
    test_flush_in_wait();
    test_timeout_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
